// File: rtl/tlb_inst_ctrl_pkg.sv
// Shared definitions for the TLB maintenance instruction sequencer.
// Contents: op encodings, TLBR exception code, TLBELO/TLBIDX field
// positions, largest legal INVTLB op, controller states, TLBELO packing.
package tlb_inst_ctrl_pkg;

  typedef enum logic [2:0] {
    TLBOP_SRCH = 3'd0,
    TLBOP_RD   = 3'd1,
    TLBOP_WR   = 3'd2,
    TLBOP_FILL = 3'd3,
    TLBOP_INV  = 3'd4
  } tlb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } ctrl_state_e;

  localparam logic [5:0] ECODE_TLBR    = 6'h3F;
  localparam logic [4:0] INVTLB_OP_MAX = 5'd6;

  // TLBELO field positions
  localparam int ELO_V      = 0;
  localparam int ELO_D      = 1;
  localparam int ELO_PLV_LO = 2;
  localparam int ELO_MAT_LO = 4;
  localparam int ELO_G      = 6;
  localparam int ELO_PPN_LO = 8;

  // TLBIDX field positions (index sits at bit 0)
  localparam int IDX_PS_LO = 24;
  localparam int IDX_NE    = 31;

  function automatic logic [31:0] pack_elo(input logic [19:0] ppn,
                                           input logic        g,
                                           input logic [1:0]  mat,
                                           input logic [1:0]  plv,
                                           input logic        d,
                                           input logic        v);
    return {4'b0, ppn, 1'b0, g, mat, plv, d, v};
  endfunction

endpackage

// File: rtl/tlb_inst_ctrl_fill_cnt.sv
// Free-running TLBFILL index counter.
// Ports: clk, reset (sync, active-high), cnt (wraps TLBNUM-1 -> 0).
module tlb_fill_cnt #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [IDXW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset)                          cnt <= '0;
    else if (cnt == IDXW'(TLBNUM - 1))  cnt <= '0;
    else                                cnt <= cnt + IDXW'(1);
  end

endmodule

// File: rtl/tlb_inst_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB between the WB-stage
// CSR logic and the tlb array.
// Ports: req_* (instruction request + INVTLB operands), csr_* (current CSR
// values), resp_* (valid/ready result for CSR update), tlb_* (s1 search,
// invtlb, write and read ports of the tlb array).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a request; operands latched on accept
// EXEC    | one cycle driving the tlb; results captured at its end
// RESP    | result held on resp_* until resp_ready
module tlb_inst_ctrl
  import tlb_inst_ctrl_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [4:0]      req_inv_op,
  input  logic [9:0]      req_inv_asid,
  input  logic [31:0]     req_inv_va,
  input  logic [31:0]     csr_tlbidx,
  input  logic [18:0]     csr_tlbehi_vppn,
  input  logic [9:0]      csr_asid,
  input  logic [31:0]     csr_tlbelo0,
  input  logic [31:0]     csr_tlbelo1,
  input  logic [5:0]      csr_estat_ecode,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [2:0]      resp_op,
  output logic            resp_err,
  output logic [31:0]     resp_tlbidx,
  output logic [18:0]     resp_tlbehi_vppn,
  output logic [31:0]     resp_tlbelo0,
  output logic [31:0]     resp_tlbelo1,
  output logic [9:0]      resp_asid,
  output logic            tlb_s1_own,
  output logic [18:0]     tlb_s1_vppn,
  output logic            tlb_s1_va_bit12,
  output logic [9:0]      tlb_s1_asid,
  input  logic            tlb_s1_found,
  input  logic [IDXW-1:0] tlb_s1_index,
  output logic            tlb_invtlb_valid,
  output logic [4:0]      tlb_invtlb_op,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic            tlb_w_e,
  output logic [18:0]     tlb_w_vppn,
  output logic [5:0]      tlb_w_ps,
  output logic [9:0]      tlb_w_asid,
  output logic            tlb_w_g,
  output logic [19:0]     tlb_w_ppn0,
  output logic [1:0]      tlb_w_plv0,
  output logic [1:0]      tlb_w_mat0,
  output logic            tlb_w_d0,
  output logic            tlb_w_v0,
  output logic [19:0]     tlb_w_ppn1,
  output logic [1:0]      tlb_w_plv1,
  output logic [1:0]      tlb_w_mat1,
  output logic            tlb_w_d1,
  output logic            tlb_w_v1,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic            tlb_r_e,
  input  logic [18:0]     tlb_r_vppn,
  input  logic [5:0]      tlb_r_ps,
  input  logic [9:0]      tlb_r_asid,
  input  logic            tlb_r_g,
  input  logic [19:0]     tlb_r_ppn0,
  input  logic [1:0]      tlb_r_plv0,
  input  logic [1:0]      tlb_r_mat0,
  input  logic            tlb_r_d0,
  input  logic            tlb_r_v0,
  input  logic [19:0]     tlb_r_ppn1,
  input  logic [1:0]      tlb_r_plv1,
  input  logic [1:0]      tlb_r_mat1,
  input  logic            tlb_r_d1,
  input  logic            tlb_r_v1
);

  ctrl_state_e     state_q, state_d;
  tlb_op_e         op_q;
  logic [4:0]      inv_op_q;
  logic [9:0]      inv_asid_q;
  logic [19:0]     inv_va_q;      // VA[31:12]
  logic [31:0]     tlbidx_q, elo0_q, elo1_q;
  logic [18:0]     ehi_q;
  logic [9:0]      asid_q;
  logic [5:0]      ecode_q;
  logic [IDXW-1:0] fill_cnt, fill_idx_q;

  logic [31:0]     tlbidx_d, elo0_d, elo1_d;
  logic [18:0]     ehi_d;
  logic [9:0]      asid_d;
  logic            err_d;
  logic            exec;
  logic            accept;

  // Bits of the CSR images that no TLB field maps to.
  logic unused_bits;
  assign unused_bits = ^{req_inv_va[11:0], elo0_q[31:28], elo0_q[7],
                         elo1_q[31:28], elo1_q[7]};

  tlb_fill_cnt #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_fill_cnt (
    .clk   (clk),
    .reset (reset),
    .cnt   (fill_cnt)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign accept     = req_valid && req_ready;
  // Gating with reset drops an in-flight WR/INV whose EXEC edge sees reset.
  assign exec       = (state_q == ST_EXEC) && !reset;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= TLBOP_SRCH;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_va_q   <= '0;
      tlbidx_q   <= '0;
      ehi_q      <= '0;
      asid_q     <= '0;
      elo0_q     <= '0;
      elo1_q     <= '0;
      ecode_q    <= '0;
      fill_idx_q <= '0;
    end else if (accept) begin
      op_q       <= tlb_op_e'(req_op);
      inv_op_q   <= req_inv_op;
      inv_asid_q <= req_inv_asid;
      inv_va_q   <= req_inv_va[31:12];
      tlbidx_q   <= csr_tlbidx;
      ehi_q      <= csr_tlbehi_vppn;
      asid_q     <= csr_asid;
      elo0_q     <= csr_tlbelo0;
      elo1_q     <= csr_tlbelo1;
      ecode_q    <= csr_estat_ecode;
      fill_idx_q <= fill_cnt;
    end
  end

  always_comb begin
    state_d          = state_q;
    tlb_s1_own       = 1'b0;
    tlb_s1_vppn      = '0;
    tlb_s1_va_bit12  = 1'b0;
    tlb_s1_asid      = '0;
    tlb_invtlb_valid = 1'b0;
    tlb_invtlb_op    = '0;
    tlb_we           = 1'b0;
    tlb_w_index      = '0;
    tlb_w_e          = 1'b0;
    tlb_w_vppn       = '0;
    tlb_w_ps         = '0;
    tlb_w_asid       = '0;
    tlb_w_g          = 1'b0;
    tlb_w_ppn0       = '0;
    tlb_w_plv0       = '0;
    tlb_w_mat0       = '0;
    tlb_w_d0         = 1'b0;
    tlb_w_v0         = 1'b0;
    tlb_w_ppn1       = '0;
    tlb_w_plv1       = '0;
    tlb_w_mat1       = '0;
    tlb_w_d1         = 1'b0;
    tlb_w_v1         = 1'b0;
    tlb_r_index      = '0;
    tlbidx_d         = tlbidx_q;
    ehi_d            = '0;
    elo0_d           = '0;
    elo1_d           = '0;
    asid_d           = '0;
    err_d            = 1'b0;

    case (state_q)
      ST_IDLE: if (req_valid)  state_d = ST_EXEC;
      ST_EXEC:                 state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase

    if (exec) begin
      case (op_q)
        TLBOP_SRCH: begin
          tlb_s1_own  = 1'b1;
          tlb_s1_vppn = ehi_q;
          tlb_s1_asid = asid_q;
          if (tlb_s1_found) begin
            tlbidx_d[IDXW-1:0] = tlb_s1_index;
            tlbidx_d[IDX_NE]   = 1'b0;
          end else begin
            tlbidx_d[IDX_NE]   = 1'b1;
          end
        end
        TLBOP_RD: begin
          tlb_r_index = tlbidx_q[IDXW-1:0];
          if (tlb_r_e) begin
            tlbidx_d[IDX_NE]          = 1'b0;
            tlbidx_d[IDX_PS_LO +: 6]  = tlb_r_ps;
            ehi_d  = tlb_r_vppn;
            asid_d = tlb_r_asid;
            elo0_d = pack_elo(tlb_r_ppn0, tlb_r_g, tlb_r_mat0, tlb_r_plv0,
                              tlb_r_d0, tlb_r_v0);
            elo1_d = pack_elo(tlb_r_ppn1, tlb_r_g, tlb_r_mat1, tlb_r_plv1,
                              tlb_r_d1, tlb_r_v1);
          end else begin
            tlbidx_d[IDX_NE]          = 1'b1;
            tlbidx_d[IDX_PS_LO +: 6]  = '0;
          end
        end
        TLBOP_WR, TLBOP_FILL: begin
          tlb_we      = 1'b1;
          tlb_w_index = (op_q == TLBOP_WR) ? tlbidx_q[IDXW-1:0] : fill_idx_q;
          // A refill handler may write an entry even while NE is set.
          tlb_w_e     = !tlbidx_q[IDX_NE] || (ecode_q == ECODE_TLBR);
          tlb_w_ps    = tlbidx_q[IDX_PS_LO +: 6];
          tlb_w_vppn  = ehi_q;
          tlb_w_asid  = asid_q;
          tlb_w_g     = elo0_q[ELO_G] & elo1_q[ELO_G];
          tlb_w_ppn0  = elo0_q[ELO_PPN_LO +: 20];
          tlb_w_plv0  = elo0_q[ELO_PLV_LO +: 2];
          tlb_w_mat0  = elo0_q[ELO_MAT_LO +: 2];
          tlb_w_d0    = elo0_q[ELO_D];
          tlb_w_v0    = elo0_q[ELO_V];
          tlb_w_ppn1  = elo1_q[ELO_PPN_LO +: 20];
          tlb_w_plv1  = elo1_q[ELO_PLV_LO +: 2];
          tlb_w_mat1  = elo1_q[ELO_MAT_LO +: 2];
          tlb_w_d1    = elo1_q[ELO_D];
          tlb_w_v1    = elo1_q[ELO_V];
        end
        TLBOP_INV: begin
          tlb_s1_own      = 1'b1;
          tlb_s1_asid     = inv_asid_q;
          tlb_s1_vppn     = inv_va_q[19:1];
          tlb_s1_va_bit12 = inv_va_q[0];
          tlb_invtlb_op   = inv_op_q;
          if (inv_op_q <= INVTLB_OP_MAX) tlb_invtlb_valid = 1'b1;
          else                           err_d            = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_op          <= '0;
      resp_err         <= 1'b0;
      resp_tlbidx      <= '0;
      resp_tlbehi_vppn <= '0;
      resp_tlbelo0     <= '0;
      resp_tlbelo1     <= '0;
      resp_asid        <= '0;
    end else if (state_q == ST_EXEC) begin
      resp_op          <= op_q;
      resp_err         <= err_d;
      resp_tlbidx      <= tlbidx_d;
      resp_tlbehi_vppn <= ehi_d;
      resp_tlbelo0     <= elo0_d;
      resp_tlbelo1     <= elo1_d;
      resp_asid        <= asid_d;
    end
  end

endmodule

// File: tb/tb_tlb_inst_ctrl.sv
module tb_tlb_inst_ctrl;

  logic        clk = 1'b0;
  logic        reset, tb_clear;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_inv_op;
  logic [9:0]  req_inv_asid;
  logic [31:0] req_inv_va;
  logic [31:0] csr_tlbidx, csr_tlbelo0, csr_tlbelo1;
  logic [18:0] csr_tlbehi_vppn;
  logic [9:0]  csr_asid;
  logic [5:0]  csr_estat_ecode;
  logic        resp_valid, resp_ready, resp_err;
  logic [2:0]  resp_op;
  logic [31:0] resp_tlbidx, resp_tlbelo0, resp_tlbelo1;
  logic [18:0] resp_tlbehi_vppn;
  logic [9:0]  resp_asid;
  logic        tlb_s1_own, tlb_s1_va_bit12, tlb_s1_found;
  logic [18:0] tlb_s1_vppn;
  logic [9:0]  tlb_s1_asid;
  logic [3:0]  tlb_s1_index;
  logic        tlb_invtlb_valid;
  logic [4:0]  tlb_invtlb_op;
  logic        tlb_we, tlb_w_e, tlb_w_g, tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
  logic [3:0]  tlb_w_index, tlb_r_index;
  logic [18:0] tlb_w_vppn;
  logic [5:0]  tlb_w_ps;
  logic [9:0]  tlb_w_asid;
  logic [19:0] tlb_w_ppn0, tlb_w_ppn1;
  logic [1:0]  tlb_w_plv0, tlb_w_mat0, tlb_w_plv1, tlb_w_mat1;
  logic        tlb_r_e, tlb_r_g, tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1;
  logic [18:0] tlb_r_vppn;
  logic [5:0]  tlb_r_ps;
  logic [9:0]  tlb_r_asid;
  logic [19:0] tlb_r_ppn0, tlb_r_ppn1;
  logic [1:0]  tlb_r_plv0, tlb_r_mat0, tlb_r_plv1, tlb_r_mat1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tlb_inst_ctrl #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_va(req_inv_va),
    .csr_tlbidx(csr_tlbidx), .csr_tlbehi_vppn(csr_tlbehi_vppn), .csr_asid(csr_asid),
    .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1), .csr_estat_ecode(csr_estat_ecode),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op), .resp_err(resp_err),
    .resp_tlbidx(resp_tlbidx), .resp_tlbehi_vppn(resp_tlbehi_vppn),
    .resp_tlbelo0(resp_tlbelo0), .resp_tlbelo1(resp_tlbelo1), .resp_asid(resp_asid),
    .tlb_s1_own(tlb_s1_own), .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_va_bit12(tlb_s1_va_bit12),
    .tlb_s1_asid(tlb_s1_asid), .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
    .tlb_invtlb_valid(tlb_invtlb_valid), .tlb_invtlb_op(tlb_invtlb_op),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e), .tlb_w_vppn(tlb_w_vppn),
    .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
    .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_plv0(tlb_w_plv0), .tlb_w_mat0(tlb_w_mat0),
    .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0),
    .tlb_w_ppn1(tlb_w_ppn1), .tlb_w_plv1(tlb_w_plv1), .tlb_w_mat1(tlb_w_mat1),
    .tlb_w_d1(tlb_w_d1), .tlb_w_v1(tlb_w_v1),
    .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_vppn(tlb_r_vppn),
    .tlb_r_ps(tlb_r_ps), .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
    .tlb_r_ppn0(tlb_r_ppn0), .tlb_r_plv0(tlb_r_plv0), .tlb_r_mat0(tlb_r_mat0),
    .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0),
    .tlb_r_ppn1(tlb_r_ppn1), .tlb_r_plv1(tlb_r_plv1), .tlb_r_mat1(tlb_r_mat1),
    .tlb_r_d1(tlb_r_d1), .tlb_r_v1(tlb_r_v1)
  );

  // Small behavioural TLB array: synchronous write, combinational read/search.
  typedef struct packed {
    logic e; logic [18:0] vppn; logic [5:0] ps; logic [9:0] asid; logic g;
    logic [19:0] ppn0; logic [1:0] plv0; logic [1:0] mat0; logic d0; logic v0;
    logic [19:0] ppn1; logic [1:0] plv1; logic [1:0] mat1; logic d1; logic v1;
  } ent_t;
  ent_t tlbm [16];
  ent_t rd;

  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 16; i++) tlbm[i] <= '0;
    end else if (tlb_we) begin
      tlbm[tlb_w_index] <= {tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g,
                            tlb_w_ppn0, tlb_w_plv0, tlb_w_mat0, tlb_w_d0, tlb_w_v0,
                            tlb_w_ppn1, tlb_w_plv1, tlb_w_mat1, tlb_w_d1, tlb_w_v1};
    end
  end

  assign rd = tlbm[tlb_r_index];
  assign {tlb_r_e, tlb_r_vppn, tlb_r_ps, tlb_r_asid, tlb_r_g,
          tlb_r_ppn0, tlb_r_plv0, tlb_r_mat0, tlb_r_d0, tlb_r_v0,
          tlb_r_ppn1, tlb_r_plv1, tlb_r_mat1, tlb_r_d1, tlb_r_v1} = rd;

  always_comb begin
    tlb_s1_found = 1'b0;
    tlb_s1_index = '0;
    for (int i = 0; i < 16; i++) begin
      if (tlbm[i].e && tlbm[i].vppn == tlb_s1_vppn &&
          (tlbm[i].g || tlbm[i].asid == tlb_s1_asid)) begin
        tlb_s1_found = 1'b1;
        tlb_s1_index = 4'(i);
      end
    end
  end

  // Expected TLBFILL index: counts every cycle out of reset, wraps at 16.
  logic [3:0] fcnt_model;
  always @(posedge clk) fcnt_model <= reset ? 4'd0 : fcnt_model + 4'd1;

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  // Called at a negedge while idle; returns at the negedge inside EXEC.
  task automatic go_exec(input logic [2:0] op);
    req_op = op; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tb_clear = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%0h exp=0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%0h exp=1", req_ready); end
    checks++; if ({tlb_we, tlb_s1_own, tlb_invtlb_valid} !== 3'b000) begin failures++; $display("FAIL rst_strobes got=%b exp=000", {tlb_we, tlb_s1_own, tlb_invtlb_valid}); end
    checks++; if (resp_tlbidx !== 32'h0) begin failures++; $display("FAIL rst_resp_tlbidx got=%h exp=0", resp_tlbidx); end
    reset = 1'b0; tb_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wr_rd();
    csr_tlbidx = 32'h0C000003; csr_tlbehi_vppn = 19'h12345; csr_asid = 10'd5;
    csr_tlbelo0 = 32'h000ABC41; csr_tlbelo1 = 32'h00000040; csr_estat_ecode = 6'd0;
    go_exec(3'd2);
    checks++; if (tlb_we !== 1'b1) begin failures++; $display("FAIL wr_we got=%0h exp=1", tlb_we); end
    checks++; if (tlb_w_index !== 4'd3) begin failures++; $display("FAIL wr_index got=%0d exp=3", tlb_w_index); end
    checks++; if ({tlb_w_e, tlb_w_g, tlb_w_v0, tlb_w_d0, tlb_w_v1} !== 5'b11100) begin failures++; $display("FAIL wr_flags got=%b exp=11100", {tlb_w_e, tlb_w_g, tlb_w_v0, tlb_w_d0, tlb_w_v1}); end
    checks++; if ({tlb_w_ps, tlb_w_vppn, tlb_w_asid, tlb_w_ppn0} !== {6'd12, 19'h12345, 10'd5, 20'h00ABC}) begin failures++; $display("FAIL wr_fields got=%h", {tlb_w_ps, tlb_w_vppn, tlb_w_asid, tlb_w_ppn0}); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL wr_exec_ready got=%0h exp=0", req_ready); end
    step();
    checks++; if (tlb_we !== 1'b0) begin failures++; $display("FAIL wr_we_one_cycle got=%0h exp=0", tlb_we); end
    checks++; if ({resp_valid, resp_op} !== {1'b1, 3'd2}) begin failures++; $display("FAIL wr_resp got=%b exp=1010", {resp_valid, resp_op}); end
    checks++; if (resp_tlbidx !== 32'h0C000003) begin failures++; $display("FAIL wr_resp_tlbidx got=%h exp=0c000003", resp_tlbidx); end
    step();
    // Back-to-back read: CSRs scrambled so only the array can supply the data.
    csr_tlbidx = 32'h80000003; csr_tlbehi_vppn = 19'h0; csr_asid = 10'd0;
    csr_tlbelo0 = 32'h0; csr_tlbelo1 = 32'h0;
    go_exec(3'd1);
    checks++; if (tlb_r_index !== 4'd3) begin failures++; $display("FAIL rd_r_index got=%0d exp=3", tlb_r_index); end
    step();
    checks++; if (resp_tlbidx !== 32'h0C000003) begin failures++; $display("FAIL rd_tlbidx got=%h exp=0c000003", resp_tlbidx); end
    checks++; if ({resp_tlbehi_vppn, resp_asid} !== {19'h12345, 10'd5}) begin failures++; $display("FAIL rd_ehi_asid got=%h/%h exp=12345/005", resp_tlbehi_vppn, resp_asid); end
    checks++; if ({resp_tlbelo0, resp_tlbelo1} !== {32'h000ABC41, 32'h00000040}) begin failures++; $display("FAIL rd_elo got=%h/%h exp=000abc41/00000040", resp_tlbelo0, resp_tlbelo1); end
    step();
  endtask

  task automatic test_rd_invalid();
    csr_tlbidx = 32'h0C000007; csr_tlbehi_vppn = 19'h55555; csr_asid = 10'h3FF;
    csr_tlbelo0 = 32'hFFFFFFFF; csr_tlbelo1 = 32'hFFFFFFFF;
    go_exec(3'd1);
    step();
    checks++; if (resp_tlbidx !== 32'h80000007) begin failures++; $display("FAIL rd7_tlbidx got=%h exp=80000007", resp_tlbidx); end
    checks++; if ({resp_tlbehi_vppn, resp_asid, resp_tlbelo0, resp_tlbelo1} !== '0) begin failures++; $display("FAIL rd7_zero got=%h/%h/%h/%h exp=0", resp_tlbehi_vppn, resp_asid, resp_tlbelo0, resp_tlbelo1); end
    step();
  endtask

  task automatic test_srch();
    csr_tlbidx = 32'h85000009; csr_tlbehi_vppn = 19'h12345; csr_asid = 10'd5;
    go_exec(3'd0);
    checks++; if ({tlb_s1_own, tlb_s1_vppn, tlb_s1_asid, tlb_s1_va_bit12} !== {1'b1, 19'h12345, 10'd5, 1'b0}) begin failures++; $display("FAIL srch_s1 got=%h", {tlb_s1_own, tlb_s1_vppn, tlb_s1_asid, tlb_s1_va_bit12}); end
    step();
    checks++; if (resp_tlbidx !== 32'h05000003) begin failures++; $display("FAIL srch_hit got=%h exp=05000003", resp_tlbidx); end
    step();
    checks++; if (tlb_s1_own !== 1'b0) begin failures++; $display("FAIL srch_own_idle got=%0h exp=0", tlb_s1_own); end
    csr_tlbidx = 32'h05000009; csr_tlbehi_vppn = 19'h00001;
    go_exec(3'd0);
    step();
    checks++; if (resp_tlbidx !== 32'h85000009) begin failures++; $display("FAIL srch_miss got=%h exp=85000009", resp_tlbidx); end
    step();
  endtask

  task automatic test_fill_wrap();
    csr_tlbidx = 32'h8C000000; csr_tlbehi_vppn = 19'h00777; csr_asid = 10'd1;
    csr_tlbelo0 = 32'h00000101; csr_tlbelo1 = 32'h0; csr_estat_ecode = 6'h3F;
    for (int k = 0; k < 40 && fcnt_model != 4'd15; k++) @(negedge clk);
    checks++; if (fcnt_model !== 4'd15) begin failures++; $display("FAIL fill_sync got=%0d exp=15", fcnt_model); end
    req_op = 3'd3; req_valid = 1'b1;
    step();
    checks++; if ({tlb_we, tlb_w_index, tlb_w_e} !== {1'b1, 4'd15, 1'b1}) begin failures++; $display("FAIL fill1 got=we%0h idx%0d e%0h exp=we1 idx15 e1", tlb_we, tlb_w_index, tlb_w_e); end
    checks++; if (tlb_w_ps !== 6'd12) begin failures++; $display("FAIL fill1_ps got=%0d exp=12", tlb_w_ps); end
    csr_estat_ecode = 6'd0;
    step();
    checks++; if ({resp_valid, resp_tlbidx} !== {1'b1, 32'h8C000000}) begin failures++; $display("FAIL fill1_resp got=%0h/%h exp=1/8c000000", resp_valid, resp_tlbidx); end
    step();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL fill_gap_ready got=%0h exp=1", req_ready); end
    step();
    req_valid = 1'b0;
    checks++; if ({tlb_we, tlb_w_index, tlb_w_e} !== {1'b1, 4'd2, 1'b0}) begin failures++; $display("FAIL fill2 got=we%0h idx%0d e%0h exp=we1 idx2 e0", tlb_we, tlb_w_index, tlb_w_e); end
    step();
    step();
  endtask

  task automatic test_invtlb();
    req_inv_op = 5'd5; req_inv_asid = 10'd5; req_inv_va = 32'h2468A000;
    go_exec(3'd4);
    checks++; if ({tlb_invtlb_valid, tlb_invtlb_op} !== {1'b1, 5'd5}) begin failures++; $display("FAIL inv5 got=%0h/%0d exp=1/5", tlb_invtlb_valid, tlb_invtlb_op); end
    checks++; if ({tlb_s1_own, tlb_s1_vppn, tlb_s1_va_bit12, tlb_s1_asid} !== {1'b1, 19'h12345, 1'b0, 10'd5}) begin failures++; $display("FAIL inv5_s1 got=%h", {tlb_s1_own, tlb_s1_vppn, tlb_s1_va_bit12, tlb_s1_asid}); end
    step();
    checks++; if ({tlb_invtlb_valid, resp_err, resp_op} !== {1'b0, 1'b0, 3'd4}) begin failures++; $display("FAIL inv5_resp got=%b exp=00100", {tlb_invtlb_valid, resp_err, resp_op}); end
    step();
    req_inv_op = 5'd9; req_inv_va = 32'h2468B000;
    go_exec(3'd4);
    checks++; if (tlb_invtlb_valid !== 1'b0) begin failures++; $display("FAIL inv9_valid got=%0h exp=0", tlb_invtlb_valid); end
    checks++; if ({tlb_s1_vppn, tlb_s1_va_bit12} !== {19'h12345, 1'b1}) begin failures++; $display("FAIL inv9_va got=%h", {tlb_s1_vppn, tlb_s1_va_bit12}); end
    step();
    checks++; if (resp_err !== 1'b1) begin failures++; $display("FAIL inv9_err got=%0h exp=1", resp_err); end
    step();
  endtask

  task automatic test_stall();
    csr_tlbidx = 32'h00000003;
    resp_ready = 1'b0;
    go_exec(3'd1);
    step();
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({resp_valid, req_ready} !== 2'b10) begin failures++; $display("FAIL stall_hs cyc%0d got=%b exp=10", k, {resp_valid, req_ready}); end
      checks++; if ({resp_tlbidx, resp_tlbehi_vppn} !== {32'h0C000003, 19'h12345}) begin failures++; $display("FAIL stall_data cyc%0d got=%h/%h", k, resp_tlbidx, resp_tlbehi_vppn); end
      step();
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    step();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL stall_release got=%b exp=01", {resp_valid, req_ready}); end
  endtask

  task automatic test_reset_in_exec();
    csr_tlbidx = 32'h00000005; csr_tlbehi_vppn = 19'h0ABCD; csr_asid = 10'd7;
    csr_tlbelo0 = 32'h00000041; csr_tlbelo1 = 32'h00000041;
    go_exec(3'd2);
    reset = 1'b1;
    #1;
    checks++; if ({tlb_we, tlb_s1_own} !== 2'b00) begin failures++; $display("FAIL rx_strobes got=%b exp=00", {tlb_we, tlb_s1_own}); end
    @(negedge clk);
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL rx_idle got=%b exp=01", {resp_valid, req_ready}); end
    checks++; if ({resp_tlbidx, resp_op} !== '0) begin failures++; $display("FAIL rx_resp_clr got=%h/%0d exp=0", resp_tlbidx, resp_op); end
    reset = 1'b0;
    csr_tlbidx = 32'h80000000; csr_estat_ecode = 6'h3F; csr_tlbehi_vppn = 19'h00888;
    go_exec(3'd3);
    checks++; if ({tlb_we, tlb_w_index} !== {1'b1, 4'd0}) begin failures++; $display("FAIL rx_fill_cnt got=we%0h idx%0d exp=we1 idx0", tlb_we, tlb_w_index); end
    step();
    step();
    csr_tlbidx = 32'h00000005;
    go_exec(3'd1);
    step();
    checks++; if (resp_tlbidx !== 32'h80000005) begin failures++; $display("FAIL rx_wr_dropped got=%h exp=80000005", resp_tlbidx); end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; tb_clear = 1'b1;
    req_valid = 1'b0; req_op = 3'd0; resp_ready = 1'b1;
    req_inv_op = '0; req_inv_asid = '0; req_inv_va = '0;
    csr_tlbidx = '0; csr_tlbehi_vppn = '0; csr_asid = '0;
    csr_tlbelo0 = '0; csr_tlbelo1 = '0; csr_estat_ecode = '0;
    test_reset();
    test_wr_rd();
    test_rd_invalid();
    test_srch();
    test_fill_wrap();
    test_invtlb();
    test_stall();
    test_reset_in_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
